// File: rtl/unidade_loadstore_pkg.sv
// Shared constants, state encoding and request-legality helpers for the load/store unit.
package pacote_loadstore;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [2:0] estado_ls_t;

  localparam estado_ls_t S_IDLE = 3'd0;
  localparam estado_ls_t S_RD   = 3'd1;
  localparam estado_ls_t S_CAP  = 3'd2;
  localparam estado_ls_t S_WR   = 3'd3;
  localparam estado_ls_t S_DONE = 3'd4;
  localparam estado_ls_t S_ERR  = 3'd5;

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic lane_ok(input logic [2:0] f3, input logic [1:0] lane);
    logic ok;
    ok = 1'b1;
    case (f3[1:0])
      2'b01:   ok = ~lane[0];
      2'b10:   ok = (lane == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic f3_ok(input logic is_load, input logic [2:0] f3);
    logic ok;
    if (is_load)
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    else
      ok = (f3 <= F3_W);
    return ok;
  endfunction

endpackage

// File: rtl/unidade_loadstore_alinhador.sv
// Lane extraction with sign/zero extension for loads, and byte/half merge for sub-word stores.
module alinhador_bytes
  import pacote_loadstore::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] storedata,
  output logic [DATA_W-1:0] load_ext,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_store_bits;

  assign unused_store_bits = ^storedata[DATA_W-1:16];

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_H:    load_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_HU:   load_ext = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_ext = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3[1:0])
      2'b00:   merged[{lane, 3'b000} +: 8] = storedata[7:0];
      2'b01:   merged[{lane[1], 4'b0000} +: 16] = storedata[15:0];
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/unidade_loadstore.sv
// Load/store unit: sole master of the data memory; sequences loads, stores and
// read-modify-write for SB/SH, flagging misaligned or illegal requests.
module unidade_loadstore
  import pacote_loadstore::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [31:0]       aluresult,
  input  logic [DATA_W-1:0] storedata,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output logic [DATA_W-1:0] loaddata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: start is honoured only in IDLE with memread or memwrite set;
  // busy stays high from the accepting edge until the cycle after done.

  estado_ls_t        estado;
  logic [1:0]        lane_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] sd_q;
  logic              rd_q;
  logic              req_err;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^aluresult[31:ADDR_W+2];

  // A request carrying both read and write is rejected before the size checks.
  always_comb begin
    req_err = 1'b0;
    if (memread && memwrite)
      req_err = 1'b1;
    else if (!f3_ok(memread, funct3) || !lane_ok(funct3, aluresult[1:0]))
      req_err = 1'b1;
  end

  assign busy   = (estado != S_IDLE);
  assign done   = (estado == S_DONE) || (estado == S_ERR);
  assign erro   = (estado == S_ERR);
  assign mem_re = (estado == S_RD);
  assign mem_we = (estado == S_WR);

  alinhador_bytes #(.DATA_W(DATA_W)) u_alinhador (
    .word      (mem_rdata),
    .lane      (lane_q),
    .funct3    (f3_q),
    .storedata (sd_q),
    .load_ext  (load_ext),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado    <= S_IDLE;
      lane_q    <= '0;
      f3_q      <= '0;
      sd_q      <= '0;
      rd_q      <= 1'b0;
      loaddata  <= '0;
      mem_wdata <= '0;
      mem_addr  <= '0;
    end else begin
      case (estado)
        S_IDLE: begin
          if (start && (memread || memwrite)) begin
            lane_q   <= aluresult[1:0];
            f3_q     <= funct3;
            sd_q     <= storedata;
            rd_q     <= memread;
            mem_addr <= aluresult[ADDR_W+1:2];
            if (req_err)
              estado <= S_ERR;
            else if (memwrite && (funct3 == F3_W)) begin
              mem_wdata <= storedata;
              estado    <= S_WR;
            end else
              estado <= S_RD;
          end
        end
        S_RD:  estado <= S_CAP;
        S_CAP: begin
          if (rd_q) begin
            loaddata <= load_ext;
            estado   <= S_DONE;
          end else begin
            mem_wdata <= merged;
            estado    <= S_WR;
          end
        end
        S_WR:    estado <= S_DONE;
        S_DONE:  estado <= S_IDLE;
        S_ERR:   estado <= S_IDLE;
        default: estado <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_loadstore.sv
// Bench for unidade_loadstore: behavioural word memory, request driver, done-time scoreboard.
module tb_unidade_loadstore;
  import pacote_loadstore::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] aluresult = 32'h0;
  logic [31:0] storedata = 32'h0;
  logic        busy, done, erro, mem_re, mem_we;
  logic [31:0] loaddata, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [4:0]  mem_addr;

  logic [31:0] mem [0:31];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = 5'd0;
  logic [31:0] pre_data = 32'h0;

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_ld = 32'h0;

  always #5 clk = ~clk;

  unidade_loadstore #(.DATA_W(32), .MEM_DEPTH(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .memread   (memread),
    .memwrite  (memwrite),
    .funct3    (funct3),
    .aluresult (aluresult),
    .storedata (storedata),
    .busy      (busy),
    .done      (done),
    .erro      (erro),
    .loaddata  (loaddata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pops one expected {erro, loaddata}.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0)
        check("unexpected_done", {31'b0, done}, 32'h0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("erro", {31'b0, erro}, {31'b0, e[32]});
        check("loaddata", loaddata, e[31:0]);
      end
    end
  end

  task automatic preload(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = idx; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_ld,
                         input int exp_re, input int exp_we, input logic [4:0] idx,
                         input logic [31:0] exp_wd, input logic poke);
    int cyc, re_c, we_c, re_n, we_n;
    logic got;
    @(negedge clk);
    check("idle_done_low", {31'b0, done}, 32'h0);
    exp_q.push_back({exp_err, exp_ld});
    start = 1'b1; memread = rd; memwrite = wr; funct3 = f3; aluresult = addr; storedata = sd;
    @(posedge clk); #1;
    start = 1'b0; memread = 1'b0; memwrite = 1'b0;
    cyc = 0; re_c = -1; we_c = -1; re_n = 0; we_n = 0; got = 1'b0;
    while (cyc < 12 && !got) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; memread = 1'b0;
      if (poke && cyc == 1) begin
        start = 1'b1; memread = 1'b1; funct3 = F3_W; aluresult = 32'h0;
      end
      check("busy", {31'b0, busy}, 32'h1);
      if (mem_re) begin
        re_n++; re_c = cyc;
        check("re_addr", {27'b0, mem_addr}, {27'b0, idx});
      end
      if (mem_we) begin
        we_n++; we_c = cyc;
        check("we_addr", {27'b0, mem_addr}, {27'b0, idx});
        check("wdata", mem_wdata, exp_wd);
      end
      if (done) got = 1'b1;
    end
    start = 1'b0; memread = 1'b0;
    check("done_seen", {31'b0, got}, 32'h1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("re_cycle", 32'(re_c), 32'(exp_re));
    check("we_cycle", 32'(we_c), 32'(exp_we));
    check("re_count", 32'(re_n), (exp_re > 0) ? 32'h1 : 32'h0);
    check("we_count", 32'(we_n), (exp_we > 0) ? 32'h1 : 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, rnd;
    logic [4:0]  ridx;
    logic [1:0]  rl;
    logic [7:0]  rb;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_erro", {31'b0, erro}, 32'h0);
    check("rst_re", {31'b0, mem_re}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_loaddata", loaddata, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_addr", {27'b0, mem_addr}, 32'h0);
    reset = 1'b0;

    preload(5'd5, 32'h823456F0);

    run_req(1, 0, F3_B,  32'h17, 0, 3, 0, 32'hFFFFFF82, 1, -1, 5'd5, 0, 0);
    run_req(1, 0, F3_BU, 32'h17, 0, 3, 0, 32'h00000082, 1, -1, 5'd5, 0, 0);
    run_req(1, 0, F3_H,  32'h16, 0, 3, 0, 32'hFFFF8234, 1, -1, 5'd5, 0, 0);
    run_req(1, 0, F3_HU, 32'h16, 0, 3, 0, 32'h00008234, 1, -1, 5'd5, 0, 0);
    last_ld = 32'h00008234;

    run_req(0, 1, F3_B, 32'h15, 32'h000000AB, 4, 0, last_ld, 1, 3, 5'd5, 32'h8234ABF0, 0);
    check("mem5_after_sb", mem[5], 32'h8234ABF0);

    run_req(0, 1, F3_W, 32'h08, 32'hDEADBEEF, 2, 0, last_ld, -1, 1, 5'd2, 32'hDEADBEEF, 0);
    run_req(1, 0, F3_W, 32'h08, 0, 3, 0, 32'hDEADBEEF, 1, -1, 5'd2, 0, 0);
    last_ld = 32'hDEADBEEF;

    run_req(1, 0, F3_W,   32'h12, 0, 1, 1, last_ld, -1, -1, 5'd0, 0, 0);
    run_req(0, 1, F3_H,   32'h03, 32'h1234, 1, 1, last_ld, -1, -1, 5'd0, 0, 0);
    run_req(1, 0, 3'b011, 32'h00, 0, 1, 1, last_ld, -1, -1, 5'd0, 0, 0);
    run_req(1, 1, F3_W,   32'h00, 0, 1, 1, last_ld, -1, -1, 5'd0, 0, 0);
    run_req(0, 1, 3'b100, 32'h00, 0, 1, 1, last_ld, -1, -1, 5'd0, 0, 0);

    // Strobe with neither read nor write must not start anything.
    @(negedge clk);
    start = 1'b1; memread = 1'b0; memwrite = 1'b0; aluresult = 32'h20;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("noop_busy", {31'b0, busy}, 32'h0);
    check("noop_re", {31'b0, mem_re}, 32'h0);

    // Reset while a SH sits in CAP: the write must never happen.
    preload(5'd1, 32'h11223344);
    @(negedge clk);
    start = 1'b1; memwrite = 1'b1; funct3 = F3_H; aluresult = 32'h06; storedata = 32'h5555;
    @(posedge clk); #1;
    start = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_done", {31'b0, done}, 32'h0);
    check("mid_rst_we", {31'b0, mem_we}, 32'h0);
    check("mid_rst_addr", {27'b0, mem_addr}, 32'h0);
    check("mid_rst_wdata", mem_wdata, 32'h0);
    check("mid_rst_loaddata", loaddata, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_we_hold", {31'b0, mem_we}, 32'h0);
    end
    reset = 1'b0;
    last_ld = 32'h0;
    @(negedge clk);
    check("mem1_untouched", mem[1], 32'h11223344);
    run_req(1, 0, F3_W, 32'h04, 0, 3, 0, 32'h11223344, 1, -1, 5'd1, 0, 0);

    preload(5'd31, 32'hCAFEF00D);
    preload(5'd0, 32'h0BADF00D);
    run_req(1, 0, F3_W, 32'h7C, 0, 3, 0, 32'hCAFEF00D, 1, -1, 5'd31, 0, 1);
    run_req(1, 0, F3_W, 32'h80, 0, 3, 0, 32'h0BADF00D, 1, -1, 5'd0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      ridx = 5'($urandom_range(8, 30));
      rl   = 2'($urandom_range(0, 3));
      rb   = 8'($urandom_range(0, 255));
      rnd  = $urandom;
      preload(ridx, rnd);
      w = rnd;
      w[rl*8 +: 8] = rb;
      run_req(0, 1, F3_B, {25'b0, ridx, rl}, {24'hA5A5A5, rb}, 4, 0, 32'h0BADF00D, 1, 3, ridx, w, 0);
      run_req(1, 0, F3_BU, {25'b0, ridx, rl}, 0, 3, 0, {24'b0, rb}, 1, -1, ridx, 0, 0);
      run_req(1, 0, F3_W, {25'b0, ridx, 2'b00}, 0, 3, 0, w, 1, -1, ridx, 0, 0);
      run_req(0, 1, F3_W, {25'b0, ridx, 2'b00}, 32'h0BADF00D ^ w, 2, 0, w, -1, 1, ridx,
              32'h0BADF00D ^ w, 0);
      run_req(1, 0, F3_W, 32'h80, 0, 3, 0, 32'h0BADF00D, 1, -1, 5'd0, 0, 0);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
